riscv_multicycle_ctrl: RTL
==========================

Name: riscv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. It sequences a shared datapath (one ALU, one unified instruction/data memory, IR, register file) through fetch, decode, execute, memory and writeback steps.
- It replaces the single-cycle main decoder for the multi-cycle build, and adds a memory handshake, an illegal-opcode trap, a memory timeout and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready before trapping. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode from IR. Stable from DECODE until return to FETCH.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  request is a store.
- adr_src  out  1  0 = PC, 1 = ALUOut as memory address.
- ir_write  out  1  load IR and OldPC.
- pc_write  out  1  load PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A.
- alu_src_b  out  2  00 = rs2 register B, 01 = immediate, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = decode funct fields.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result direct.
- illegal_op  out  1  sticky: unsupported opcode or memory timeout.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to FETCH, instr_count=0, illegal_op=0, wait counter=0.
  - All combinational outputs take their FETCH values, with mem_ready treated as 0.
  - Reset mid-access abandons the request; no write strobe survives into the next cycle.
- Outputs are combinational from state plus inputs. Every output defaults to 0 unless listed.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10.
  - ir_write and pc_write equal mem_ready.
  - Next state: DECODE on mem_ready, otherwise stay.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - imm_src: 10 if op=1100011, 11 if op=1101111, else 00.
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other -> TRAP.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00, imm_src=01 if op[5] else 00.
  - Next state: MEMWRITE if op[5], else MEMREAD.
- MEMREAD:
  - Outputs: mem_req=1, adr_src=1.
  - Next state: MEMWB on mem_ready.
- MEMWB:
  - Outputs: result_src=01, reg_write=1.
  - Next state: FETCH; the instruction retires.
- MEMWRITE:
  - Outputs: mem_req=1, mem_write=1, adr_src=1.
  - Next state: FETCH on mem_ready; the instruction retires.
- EXECR:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
  - Next state: ALUWB.
- EXECI:
  - Outputs: alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: result_src=00, reg_write=1.
  - Next state: FETCH; the instruction retires.
- BEQ:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero.
  - Next state: FETCH; the instruction retires whether or not the branch is taken.
- JAL:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC=target, ALU computes OldPC+4).
  - Next state: ALUWB; the link is written and retires there.
- TRAP:
  - All strobes are 0 and illegal_op=1.
  - No exit except reset.
- Retire: instr_count increments by 1 in the cycle the state leaves MEMWB, ALUWB, BEQ, or MEMWRITE (with mem_ready=1). It wraps from all-ones to 0.
- Timeout:
  - Wait counter counts consecutive cycles in FETCH, MEMREAD or MEMWRITE with mem_ready=0, and clears on mem_ready or on a state change.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT, the next state is TRAP instead of staying.
  - mem_ready in the same cycle as the limit wins: the access completes normally.
- Single request in flight: mem_req never deasserts while waiting except on reset or timeout.

Test Plan:
- Reset, then lw (op=0000011) with mem_ready=1 always -> states 0,1,2,3,4,0 (5 cycles). reg_write=1 only in MEMWB with result_src=01. instr_count=1.
- sw (0100011), mem_ready held low 3 cycles in MEMWRITE -> mem_req=mem_write=1 for 4 cycles. imm_src=01 in MEMADR. reg_write never set. instr_count increments once.
- beq with zero=1, then beq with zero=0 -> pc_write=1 in BEQ only for the first. Both return to FETCH. instr_count=2.
- jal (1101111) -> DECODE imm_src=11, JAL pc_write=1, ALUWB reg_write=1. Sequence 0,1,10,8,0.
- op=1111111 -> TRAP at cycle 3, illegal_op=1, all strobes 0 for 20 cycles. rst_n pulse low -> FETCH, illegal_op=0.
- mem_ready stuck 0 in FETCH with MEM_TIMEOUT=16 -> TRAP after 16 wait cycles. Repeat with mem_ready=1 on the 16th cycle -> DECODE, no trap.

Source files
------------

// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared datapath.
//   op, zero, mem_ready          : datapath/memory status into the controller
//   mem_req, mem_write, adr_src  : unified memory request and address select
//   ir_write, pc_write, reg_write: architectural state write strobes
//   alu_src_a/b, alu_op, imm_src : ALU operand, operation and immediate selects
//   result_src                   : writeback/PC result mux select
// master = controller side, slave = datapath side.
interface riscv_multicycle_ctrl_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic [1:0] result_src;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, alu_op, imm_src, result_src
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    input  alu_src_a, alu_src_b, alu_op, imm_src, result_src
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM. Sequences the shared datapath through fetch, decode,
// execute, memory and writeback, with a memory handshake, an illegal-opcode trap,
// a memory-wait timeout and a retired-instruction counter.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : control bundle (master side), see riscv_multicycle_ctrl_if
//   illegal_op   : sticky trap flag (bad opcode or memory timeout)
//   instr_count  : retired instructions, wraps modulo 2^CNT_W
//   state_dbg    : current state encoding
module riscv_multicycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  riscv_multicycle_ctrl_if.master       bus,
  output logic                          illegal_op,
  output logic [CNT_W-1:0]              instr_count,
  output logic [3:0]                    state_dbg
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Compare against the count before this cycle, so the trap fires on the
  // MEM_TIMEOUT-th consecutive wait cycle.
  localparam logic [WaitW-1:0] WaitLimit =
      (MEM_TIMEOUT == 0) ? '0 : WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] count_q;
  logic             illegal_q;
  logic             retire;
  logic             ready;
  logic             waiting;
  logic             timeout;

  // During reset the request must not complete, so mem_ready is masked.
  assign ready   = bus.mem_ready & rst_n;
  assign waiting = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign timeout = (MEM_TIMEOUT != 0) && waiting && !ready && (wait_q == WaitLimit);

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.imm_src    = 2'b00;
    bus.result_src = 2'b00;

    unique case (state_q)
      StFetch: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = ready;
        bus.pc_write   = ready;
        if (ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch/jump target into ALUOut.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        if (bus.op == OpBranch)   bus.imm_src = 2'b10;
        else if (bus.op == OpJal) bus.imm_src = 2'b11;
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = bus.op[5] ? 2'b01 : 2'b00;
        state_d       = bus.op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
        state_d        = StFetch;
        retire         = 1'b1;
      end
      StMemWrite: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
        if (ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b10;
        state_d       = StAluWb;
      end
      StExecI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = 2'b10;
        state_d       = StAluWb;
      end
      StAluWb: begin
        bus.reg_write = 1'b1;
        state_d       = StFetch;
        retire        = 1'b1;
      end
      StBeq: begin
        bus.alu_src_a = 2'b10;
        bus.alu_op    = 2'b01;
        bus.pc_write  = bus.zero;
        state_d       = StFetch;
        retire        = 1'b1;
      end
      StJal: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link.
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
        state_d       = StAluWb;
      end
      StTrap: state_d = StTrap;
      default: state_d = StTrap;
    endcase

    if (timeout) state_d = StTrap;
  end

  always_comb begin
    wait_d = '0;
    if (waiting && !ready && (state_d == state_q) && (wait_q != '1)) wait_d = wait_q + 1'b1;
    else if (waiting && !ready && (state_d == state_q))              wait_d = wait_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_q | (state_d == StTrap);
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  assign illegal_op  = illegal_q;
  assign instr_count = count_q;
  assign state_dbg   = state_q;

endmodule
